// File: rtl/dense_readout_pkg.sv
// rtl/dense_readout_pkg.sv - shared types and default sizes for the logit readout
//
// Purpose: readout FSM state encoding, default layer geometry and the
//          class index width derived from the number of classes.
// Ports:   none (package).

package dense_readout_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        DONE = 2'd2
    } readout_state_t;

    localparam int DEF_NUM_CLASSES = 10;
    localparam int DEF_DATA_W      = 64;
    localparam int DEF_ADDR_STRIDE = 16;
    localparam int CLASS_IDX_W     = $clog2(DEF_NUM_CLASSES);

endpackage

// File: rtl/signed_max_tracker.sv
// rtl/signed_max_tracker.sv - running signed maximum and its index
//
// Purpose: keeps the largest signed value seen so far and the index it came
//          from. init reloads from the current element; otherwise an element
//          replaces the held one only when strictly greater, so ties keep
//          the earlier (lower) index.
// Ports:
//   clk_i    in  clock, rising edge
//   reset_i  in  synchronous active-high reset
//   init_i   in  treat the current element as the first one
//   en_i     in  current element is valid this cycle
//   data_i   in  element value, two's complement
//   idx_i    in  element index
//   max_o    out maximum including the current element (combinational)
//   arg_o    out index of max_o (combinational)

module signed_max_tracker #(
    parameter int DATA_W = 64,
    parameter int IDX_W  = 4
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              init_i,
    input  logic              en_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [IDX_W-1:0]  idx_i,
    output logic [DATA_W-1:0] max_o,
    output logic [IDX_W-1:0]  arg_o
);

    logic [DATA_W-1:0] max_q, max_d;
    logic [IDX_W-1:0]  arg_q, arg_d;

    always_comb begin
        max_d = max_q;
        arg_d = arg_q;
        if (en_i && (init_i || ($signed(data_i) > $signed(max_q)))) begin
            max_d = data_i;
            arg_d = idx_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            max_q <= '0;
            arg_q <= '0;
        end else begin
            max_q <= max_d;
            arg_q <= arg_d;
        end
    end

    // Exposing the next-state lets the caller capture the final result on
    // the same edge that samples the last element.
    assign max_o = max_d;
    assign arg_o = arg_d;

endmodule

// File: rtl/dense_argmax_readout.sv
// rtl/dense_argmax_readout.sv - reads the dense layer logits and reports argmax
//
// Purpose: on start, walks the layer read port over NUM_CLASSES logits at
//          ADDR_STRIDE byte steps, waiting READ_LATENCY cycles per address,
//          and publishes the winning class index and logit.
// Ports:
//   clk_i        in  clock, rising edge
//   reset_i      in  synchronous active-high reset
//   start_i      in  one-cycle request, ignored unless idle
//   rd_addr_o    out read address to the layer
//   rd_data_i    in  logit returned by the layer
//   busy_o       out readout in progress (READ or DONE)
//   done_o       out one-cycle pulse as the result is published
//   class_idx_o  out index of the maximum logit
//   max_value_o  out maximum logit, signed
//   out_valid_o  out class_idx_o/max_value_o hold a completed result

module dense_argmax_readout
    import dense_readout_pkg::*;
#(
    parameter int NUM_CLASSES  = DEF_NUM_CLASSES,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int ADDR_W       = 32,
    parameter int ADDR_STRIDE  = DEF_ADDR_STRIDE,
    parameter int READ_LATENCY = 0
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   start_i,
    output logic [ADDR_W-1:0]      rd_addr_o,
    input  logic [DATA_W-1:0]      rd_data_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [CLASS_IDX_W-1:0] class_idx_o,
    output logic [DATA_W-1:0]      max_value_o,
    output logic                   out_valid_o
);

    localparam int WAIT_W = (READ_LATENCY > 0) ? $clog2(READ_LATENCY + 1) : 1;
    localparam logic [WAIT_W-1:0]      WAIT_LOAD = WAIT_W'(READ_LATENCY);
    localparam logic [CLASS_IDX_W-1:0] LAST_IDX  = CLASS_IDX_W'(NUM_CLASSES - 1);

    readout_state_t         state_q, state_d;
    logic [CLASS_IDX_W-1:0] idx_q, idx_d;
    logic [WAIT_W-1:0]      wait_q, wait_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [CLASS_IDX_W-1:0] cls_q, cls_d;
    logic [DATA_W-1:0]      maxv_q, maxv_d;
    logic                   valid_q, valid_d;

    logic                   sample;
    logic [ADDR_W-1:0]      addr_next;
    logic [DATA_W-1:0]      trk_max;
    logic [CLASS_IDX_W-1:0] trk_arg;

    assign sample    = (state_q == READ) && (wait_q == '0);
    assign addr_next = ADDR_W'((32'(idx_q) + 32'd1) * 32'(ADDR_STRIDE));

    signed_max_tracker #(
        .DATA_W (DATA_W),
        .IDX_W  (CLASS_IDX_W)
    ) u_tracker (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .init_i  (idx_q == '0),
        .en_i    (sample),
        .data_i  (rd_data_i),
        .idx_i   (idx_q),
        .max_o   (trk_max),
        .arg_o   (trk_arg)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wait_d  = wait_q;
        addr_d  = addr_q;
        cls_d   = cls_q;
        maxv_d  = maxv_q;
        valid_d = valid_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    addr_d  = '0;
                    idx_d   = '0;
                    wait_d  = WAIT_LOAD;
                    valid_d = 1'b0;
                    state_d = READ;
                end
            end
            READ: begin
                if (wait_q != '0) begin
                    wait_d = wait_q - 1'b1;
                end else if (idx_q < LAST_IDX) begin
                    idx_d  = idx_q + 1'b1;
                    addr_d = addr_next;
                    wait_d = WAIT_LOAD;
                end else begin
                    maxv_d  = trk_max;
                    cls_d   = trk_arg;
                    state_d = DONE;
                end
            end
            DONE: begin
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            wait_q  <= '0;
            addr_q  <= '0;
            cls_q   <= '0;
            maxv_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wait_q  <= wait_d;
            addr_q  <= addr_d;
            cls_q   <= cls_d;
            maxv_q  <= maxv_d;
            valid_q <= valid_d;
        end
    end

    assign rd_addr_o   = addr_q;
    assign busy_o      = (state_q != IDLE);
    assign done_o      = (state_q == DONE);
    assign class_idx_o = cls_q;
    assign max_value_o = maxv_q;
    assign out_valid_o = valid_q;

endmodule

// File: tb/tb_dense_argmax_readout.sv
// tb/tb_dense_argmax_readout.sv - bench for dense_argmax_readout

module tb_dense_argmax_readout;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic        start0, start1;
    logic [31:0] addr0, addr1;
    logic [63:0] data0, data1;
    logic        busy0, busy1, done0, done1, ov0, ov1;
    logic [3:0]  cls0, cls1;
    logic [63:0] max0, max1;

    logic signed [63:0] mem0 [10];
    logic signed [63:0] mem1 [10];
    logic [31:0] a1d1, a1d2;

    int                 prev_cls [2];
    logic signed [63:0] prev_max [2];

    dense_argmax_readout #(.READ_LATENCY(0)) dut0 (
        .clk_i(clk), .reset_i(reset), .start_i(start0), .rd_addr_o(addr0),
        .rd_data_i(data0), .busy_o(busy0), .done_o(done0), .class_idx_o(cls0),
        .max_value_o(max0), .out_valid_o(ov0)
    );

    dense_argmax_readout #(.READ_LATENCY(2)) dut1 (
        .clk_i(clk), .reset_i(reset), .start_i(start1), .rd_addr_o(addr1),
        .rd_data_i(data1), .busy_o(busy1), .done_o(done1), .class_idx_o(cls1),
        .max_value_o(max1), .out_valid_o(ov1)
    );

    // Layer models: combinational port, and a port returning data two cycles
    // after the address changes.
    always_comb begin
        data0 = '0;
        if (addr0[31:4] < 28'd10 && addr0[3:0] == 4'd0) data0 = mem0[addr0[7:4]];
    end

    always @(posedge clk) begin
        a1d1 <= addr1;
        a1d2 <= a1d1;
    end

    always_comb begin
        data1 = 64'hDEAD_BEEF_DEAD_BEEF;
        if (a1d2[31:4] < 28'd10 && a1d2[3:0] == 4'd0) data1 = mem1[a1d2[7:4]];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_start(input int sel, input logic v);
        if (sel == 0) start0 = v;
        else start1 = v;
    endtask

    task automatic get_outs(input int sel, output logic [31:0] a, output logic b,
                            output logic d, output logic [3:0] c,
                            output logic [63:0] m, output logic v);
        if (sel == 0) begin
            a = addr0; b = busy0; d = done0; c = cls0; m = max0; v = ov0;
        end else begin
            a = addr1; b = busy1; d = done1; c = cls1; m = max1; v = ov1;
        end
    endtask

    // Highest value wins; on equal values the first occurrence stays.
    function automatic void ref_argmax(input logic signed [63:0] v [10],
                                       output int ai, output logic signed [63:0] mx);
        ai = 0;
        for (int i = 0; i < 10; i++) begin
            int better = 1;
            for (int k = 0; k < 10; k++) begin
                if (v[k] > v[i] || (v[k] == v[i] && k < i)) better = 0;
            end
            if (better == 1) ai = i;
        end
        mx = v[ai];
    endfunction

    task automatic check_reset_state(input int sel);
        logic [31:0] a; logic b, d, v; logic [3:0] c; logic [63:0] m;
        get_outs(sel, a, b, d, c, m, v);
        chk("rst_addr", 64'(a), 64'd0);
        chk("rst_busy", 64'(b), 64'd0);
        chk("rst_done", 64'(d), 64'd0);
        chk("rst_class", 64'(c), 64'd0);
        chk("rst_max", m, 64'd0);
        chk("rst_valid", 64'(v), 64'd0);
    endtask

    // One readout; inj_a/inj_b are cycle offsets at which an extra start is
    // presented (-1 for none).
    task automatic run_readout(input int sel, input int lat, input int inj_a, input int inj_b);
        logic signed [63:0] v [10];
        int ei; logic signed [63:0] em; int last;
        logic [31:0] a; logic b, d, ov; logic [3:0] c; logic [63:0] m;
        for (int i = 0; i < 10; i++) v[i] = (sel == 0) ? mem0[i] : mem1[i];
        ref_argmax(v, ei, em);
        last = 10 * (lat + 1);
        @(negedge clk);
        set_start(sel, 1'b1);
        @(posedge clk);
        #1 set_start(sel, 1'b0);
        for (int j = 0; j <= last + 2; j++) begin
            @(negedge clk);
            get_outs(sel, a, b, d, c, m, ov);
            if (j < last) chk("addr", 64'(a), 64'((j / (lat + 1)) * 16));
            chk("busy", 64'(b), 64'(j <= last));
            chk("done", 64'(d), 64'(j == last));
            chk("out_valid", 64'(ov), 64'(j > last));
            chk("class_idx", 64'(c), (j >= last) ? 64'(ei) : 64'(prev_cls[sel]));
            chk("max_value", m, (j >= last) ? em : prev_max[sel]);
            set_start(sel, (j == inj_a || j == inj_b));
        end
        set_start(sel, 1'b0);
        prev_cls[sel] = ei;
        prev_max[sel] = em;
    endtask

    initial begin
        logic signed [63:0] set_a [10];
        logic signed [63:0] set_n [10];
        set_a = '{64'sd5, -64'sd3, 64'sd12, 64'sd7, 64'sd0, -64'sd100, 64'sd11, 64'sd2, 64'sd12, 64'sd4};
        set_n = '{-64'sd9, -64'sd2, -64'sd50, -64'sd7, -64'sd20, -64'sd3, -64'sd8, -64'sd100, -64'sd5, -64'sd2};
        reset = 1'b1;
        start0 = 1'b0;
        start1 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            mem0[i] = '0;
            mem1[i] = '0;
        end
        prev_cls = '{0, 0};
        prev_max = '{64'sd0, 64'sd0};
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_state(0);
        check_reset_state(1);
        reset = 1'b0;

        // Tie between indices 2 and 8 keeps 2.
        mem0 = set_a;
        run_readout(0, 0, -1, -1);
        chk("dir_class_tie", 64'(cls0), 64'd2);
        chk("dir_max_tie", max0, 64'd12);

        // All negative: signed compare and first-element init.
        mem0 = set_n;
        run_readout(0, 0, -1, -1);
        chk("dir_class_neg", 64'(cls0), 64'd1);
        chk("dir_max_neg", max0, -64'sd2);

        // Latency 2, winner at the last slot.
        for (int i = 0; i < 9; i++) mem1[i] = $signed({$urandom, $urandom}) >>> 2;
        mem1[9] = 64'sh4000_0000_0000_0000;
        run_readout(1, 2, -1, -1);
        chk("dir_class_lat2", 64'(cls1), 64'd9);

        // Starts mid-readout and alongside done are ignored.
        mem0 = set_a;
        run_readout(0, 0, 4, 10);
        run_readout(1, 2, 13, 30);

        // Reset while class 5 is being read.
        for (int i = 0; i < 10; i++) mem0[i] = $signed({$urandom, $urandom});
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk);
        #1 start0 = 1'b0;
        repeat (6) @(negedge clk);
        chk("pre_reset_addr", 64'(addr0), 64'd80);
        reset = 1'b1;
        @(negedge clk);
        check_reset_state(0);
        check_reset_state(1);
        reset = 1'b0;
        prev_cls = '{0, 0};
        prev_max = '{64'sd0, 64'sd0};
        run_readout(0, 0, -1, -1);

        // Back-to-back random sets, with occasional forced ties.
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 10; i++) begin
                mem0[i] = $signed({$urandom, $urandom});
                mem1[i] = (r % 2 == 0) ? $signed(64'($urandom_range(0, 7)) - 64'd4)
                                       : $signed({$urandom, $urandom});
            end
            if (r == 3) mem0[7] = mem0[$urandom_range(0, 6)];
            run_readout(0, 0, -1, -1);
            run_readout(1, 2, -1, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
